// File: rtl/npu_cmd_scheduler_if.sv
// npu_cmd_scheduler_if: host command bus plus NPU controller handshake bundle
// Ports (slave side = scheduler):
//   cmd_valid_i/cmd_op_i/cmd_ready_o : host command offer and acceptance
//   flush_i                          : drop queued, not-yet-issued commands
//   op_type_o/op_end_i               : one-cycle opcode pulse out, completion level in
//   busy_o/pending_o/done_cnt_o      : progress reporting
//   err_o/err_clr_i                  : sticky error flag and its clear
interface npu_cmd_scheduler_if #(
  parameter int DEPTH = 4
);
  logic                   cmd_valid_i;
  logic [1:0]             cmd_op_i;
  logic                   cmd_ready_o;
  logic                   flush_i;
  logic [3:0]             op_type_o;
  logic                   op_end_i;
  logic                   busy_o;
  logic [$clog2(DEPTH):0] pending_o;
  logic [15:0]            done_cnt_o;
  logic                   err_o;
  logic                   err_clr_i;
  modport slave (
    input  cmd_valid_i, cmd_op_i, flush_i, op_end_i, err_clr_i,
    output cmd_ready_o, op_type_o, busy_o, pending_o, done_cnt_o, err_o
  );
  modport master (
    output cmd_valid_i, cmd_op_i, flush_i, op_end_i, err_clr_i,
    input  cmd_ready_o, op_type_o, busy_o, pending_o, done_cnt_o, err_o
  );
endinterface

// File: rtl/npu_cmd_scheduler.sv
// npu_cmd_scheduler: queues host commands and issues them one at a time to the NPU controller
// Ports: clk_i, rst_ni (async, active-low), bus (npu_cmd_scheduler_if.slave).
module npu_cmd_scheduler #(
  parameter int DWidth     = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 4096
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  npu_cmd_scheduler_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 8 || DWidth < 1 || ADDR_WIDTH < 1) begin : g_param_chk
    $error("npu_cmd_scheduler: illegal parameters");
  end
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_END, WAIT_CLR} state_e;
  state_e        state_q, state_d;
  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    op_q, op_d;
  logic [15:0]   done_q, done_d;
  logic          busy_q, err_q, err_d;
  logic          legal, push, pop, tmo;
  assign bus.cmd_ready_o = (cnt_q < (AW+1)'(DEPTH)) & ~bus.flush_i;
  // 01 and 10 are the only legal opcodes: exactly one bit set
  assign legal = ^bus.cmd_op_i;
  assign push  = bus.cmd_valid_i & bus.cmd_ready_o & legal;
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    op_d    = 4'h0;
    done_d  = done_q;
    pop     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: if (cnt_q != '0 && !bus.op_end_i) begin
        pop     = 1'b1;
        op_d    = (mem_q[rd_q] == 2'b01) ? 4'hF : 4'h1;
        state_d = ISSUE;
      end
      ISSUE: begin
        tmr_d   = '0;
        state_d = WAIT_END;
      end
      WAIT_END: if (bus.op_end_i) state_d = WAIT_CLR;
      else if (tmr_q == TW'(TIMEOUT - 1)) begin
        tmo     = 1'b1;
        done_d  = done_q + 16'd1;
        state_d = IDLE;
      end else tmr_d = tmr_q + TW'(1);
      WAIT_CLR: if (!bus.op_end_i) begin
        done_d  = done_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // flush also discards a same-cycle pop's bookkeeping; the popped command is already in flight
    cnt_d = bus.flush_i ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    err_d = (bus.cmd_valid_i & bus.cmd_ready_o & ~legal) | tmo | (err_q & ~bus.err_clr_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      op_q    <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= bus.flush_i ? wr_q : rd_q + AW'(pop);
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      op_q    <= op_d;
      done_q  <= done_d;
      busy_q  <= state_d != IDLE;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk_i) if (push) mem_q[wr_q] <= bus.cmd_op_i;
  assign bus.op_type_o  = op_q;
  assign bus.busy_o     = busy_q;
  assign bus.pending_o  = cnt_q;
  assign bus.done_cnt_o = done_q;
  assign bus.err_o      = err_q;
endmodule

// File: tb/tb_npu_cmd_scheduler.sv
// tb_npu_cmd_scheduler: vector table, directed corner sequences and random traffic against a queue-based reference
module tb_npu_cmd_scheduler;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 4096;
  logic clk_i, rst_ni;
  int checks = 0, errors = 0;
  npu_cmd_scheduler_if #(.DEPTH(DEPTH)) bus();
  npu_cmd_scheduler #(.DWidth(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus)
  );
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic auto_en = 1'b0, oe_man = 1'b0, oe_auto = 1'b0, no_resp = 1'b0, rnd = 1'b0;
  assign bus.op_end_i = auto_en ? oe_auto : oe_man;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic [25:0] outs();
    return {bus.cmd_ready_o, bus.op_type_o, bus.busy_o, bus.pending_o, bus.done_cnt_o, bus.err_o};
  endfunction
  // Controller model: after an opcode pulse, wait a while, then hold op_end high for a few cycles.
  int c_dly, c_hi;
  logic c_act = 1'b0;
  initial forever begin
    @(negedge clk_i);
    if (!rst_ni) begin
      oe_auto = 1'b0;
      c_act   = 1'b0;
    end else if (c_act) begin
      if (c_dly > 0) c_dly--;
      else if (!oe_auto) oe_auto = 1'b1;
      else if (c_hi > 1) c_hi--;
      else begin
        oe_auto = 1'b0;
        c_act   = 1'b0;
      end
    end else if (auto_en && !no_resp && bus.op_type_o != 4'h0) begin
      c_act = 1'b1;
      c_dly = rnd ? int'($urandom_range(0, 8)) : 30;
      c_hi  = rnd ? int'($urandom_range(1, 4)) : 3;
    end
  end
  // Reference: a command queue plus an "in flight" record, advanced once per clock edge.
  int          mq[$];
  logic [3:0]  seen_ops[$];
  logic        m_on = 1'b0, m_busy, m_pulse, m_end, m_err;
  int          m_wait;
  logic [15:0] m_done;
  logic [3:0]  m_op;
  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_pulse = 0; m_end = 0; m_err = 0; m_wait = 0; m_done = 0; m_op = 0; m_on = 1;
  endtask
  task automatic model_step();
    logic acc, lgl, tmo, oe;
    oe  = bus.op_end_i;
    acc = bus.cmd_valid_i && mq.size() < DEPTH && !bus.flush_i;
    lgl = bus.cmd_op_i == 2'b01 || bus.cmd_op_i == 2'b10;
    tmo = 0;
    m_op = 0;
    if (m_busy) begin
      if (m_pulse) begin
        m_pulse = 0;
        m_wait  = 0;
      end else if (!m_end) begin
        if (oe) m_end = 1;
        else if (m_wait == TIMEOUT - 1) begin
          tmo = 1; m_busy = 0; m_done++;
        end else m_wait++;
      end else if (!oe) begin
        m_busy = 0; m_done++;
      end
    end else if (mq.size() > 0 && !oe) begin
      m_op = (mq.pop_front() == 1) ? 4'hF : 4'h1;
      m_busy = 1; m_pulse = 1; m_end = 0;
    end
    if (bus.flush_i) mq.delete();
    if (acc && lgl) mq.push_back(int'(bus.cmd_op_i));
    m_err = (acc && !lgl) || tmo || (m_err && !bus.err_clr_i);
  endtask
  initial forever begin
    @(posedge clk_i or negedge rst_ni);
    if (!rst_ni) model_reset();
    else if (m_on) model_step();
    #1;
    if (m_on) begin
      chk("model", 64'(outs()), 64'({mq.size() < DEPTH && !bus.flush_i, m_op, m_busy, 3'(mq.size()), m_done, m_err}));
      if (rst_ni && bus.op_type_o != 4'h0) seen_ops.push_back(bus.op_type_o);
    end
  end
  function automatic logic [63:0] pk();
    logic [63:0] r = '0;
    foreach (seen_ops[i]) r = {r[59:0], seen_ops[i]};
    return r;
  endfunction
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask
  task automatic drive(input logic v, input logic [1:0] op, input logic fl, input logic clr);
    bus.cmd_valid_i = v; bus.cmd_op_i = op; bus.flush_i = fl; bus.err_clr_i = clr;
  endtask
  task automatic wait_done(input logic [15:0] tgt, input int lim, input string nm);
    int g = 0;
    while (bus.done_cnt_o != tgt && g < lim) begin tick(); g++; end
    chk(nm, 64'(bus.done_cnt_o), 64'(tgt));
  endtask
  task automatic push_cmd(input logic [1:0] op, input string nm);
    int g = 0;
    drive(1, op, 0, 0);
    #1;
    while (!bus.cmd_ready_o && g < 500) begin tick(); #1; g++; end
    if (g == 500) chk(nm, 0, 1);
    tick();
    drive(0, 0, 0, 0);
  endtask
  typedef struct {
    logic v; logic [1:0] op; logic fl, oe, clr;
    logic r; logic [3:0] ot; logic b; logic [2:0] p; logic [15:0] d; logic e;
  } vec_t;
  vec_t tbl[19];
  logic [15:0] base;
  initial begin
    tbl[0]  = '{1, 2'b01, 0, 0, 0, 1, 4'h0, 0, 3'd1, 16'd0, 0};
    tbl[1]  = '{0, 2'b00, 0, 0, 0, 1, 4'hF, 1, 3'd0, 16'd0, 0};
    tbl[2]  = '{0, 2'b00, 0, 0, 0, 1, 4'h0, 1, 3'd0, 16'd0, 0};
    tbl[3]  = '{0, 2'b00, 0, 1, 0, 1, 4'h0, 1, 3'd0, 16'd0, 0};
    tbl[4]  = '{0, 2'b00, 0, 1, 0, 1, 4'h0, 1, 3'd0, 16'd0, 0};
    tbl[5]  = '{0, 2'b00, 0, 0, 0, 1, 4'h0, 0, 3'd0, 16'd1, 0};
    tbl[6]  = '{1, 2'b00, 0, 0, 0, 1, 4'h0, 0, 3'd0, 16'd1, 1};
    tbl[7]  = '{1, 2'b11, 0, 0, 0, 1, 4'h0, 0, 3'd0, 16'd1, 1};
    tbl[8]  = '{0, 2'b00, 0, 0, 1, 1, 4'h0, 0, 3'd0, 16'd1, 0};
    tbl[9]  = '{1, 2'b10, 0, 1, 0, 1, 4'h0, 0, 3'd1, 16'd1, 0};
    tbl[10] = '{0, 2'b00, 0, 1, 0, 1, 4'h0, 0, 3'd1, 16'd1, 0};
    tbl[11] = '{0, 2'b00, 0, 0, 0, 1, 4'h1, 1, 3'd0, 16'd1, 0};
    tbl[12] = '{0, 2'b00, 0, 0, 0, 1, 4'h0, 1, 3'd0, 16'd1, 0};
    tbl[13] = '{0, 2'b00, 0, 1, 0, 1, 4'h0, 1, 3'd0, 16'd1, 0};
    tbl[14] = '{0, 2'b00, 0, 0, 0, 1, 4'h0, 0, 3'd0, 16'd2, 0};
    tbl[15] = '{1, 2'b01, 1, 0, 0, 0, 4'h0, 0, 3'd0, 16'd2, 0};
    tbl[16] = '{1, 2'b11, 0, 0, 1, 1, 4'h0, 0, 3'd0, 16'd2, 1};
    tbl[17] = '{0, 2'b00, 0, 0, 1, 1, 4'h0, 0, 3'd0, 16'd2, 0};
    tbl[18] = '{0, 2'b00, 0, 0, 0, 1, 4'h0, 0, 3'd0, 16'd2, 0};
    rst_ni = 1'b1;
    drive(0, 0, 0, 0);
    #3 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    tick();
    chk("reset", 64'(outs()), 64'({1'b1, 4'h0, 1'b0, 3'd0, 16'd0, 1'b0}));
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].fl, tbl[i].clr);
      oe_man = tbl[i].oe;
      #1 chk($sformatf("vec%0d_ready", i), 64'(bus.cmd_ready_o), 64'(tbl[i].r));
      tick();
      chk($sformatf("vec%0d_out", i), 64'({bus.op_type_o, bus.busy_o, bus.pending_o, bus.done_cnt_o, bus.err_o}),
          64'({tbl[i].ot, tbl[i].b, tbl[i].p, tbl[i].d, tbl[i].e}));
    end
    drive(0, 0, 0, 0);
    oe_man = 0;
    // queue full: five commands against a slow controller
    auto_en = 1;
    seen_ops.delete();
    base = bus.done_cnt_o;
    for (int k = 0; k < 5; k++) push_cmd((k % 2) ? 2'b10 : 2'b01, "full_push");
    #1 chk("full_state", 64'({bus.pending_o, bus.cmd_ready_o}), 64'({3'd4, 1'b0}));
    wait_done(base + 16'd5, 2000, "full_done");
    chk("full_order", pk(), 64'hF1F1F);
    // timeout: first command never answered, second issues afterwards
    seen_ops.delete();
    base = bus.done_cnt_o;
    no_resp = 1;
    push_cmd(2'b01, "tmo_push");
    push_cmd(2'b10, "tmo_push");
    begin
      int g = 0;
      while (!bus.err_o && g < TIMEOUT + 100) begin tick(); g++; end
    end
    no_resp = 0;
    chk("tmo_err", 64'({bus.err_o, bus.done_cnt_o}), 64'({1'b1, base + 16'd1}));
    wait_done(base + 16'd2, 500, "tmo_next_done");
    chk("tmo_order", pk(), 64'hF1);
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    chk("tmo_clr", 64'(bus.err_o), 64'd0);
    // flush: one in flight, three queued, flush with a simultaneous offer
    seen_ops.delete();
    base = bus.done_cnt_o;
    for (int k = 0; k < 4; k++) push_cmd(2'b10, "fl_push");
    chk("fl_pending", 64'({bus.pending_o, bus.busy_o}), 64'({3'd3, 1'b1}));
    drive(1, 2'b01, 1, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("fl_cleared", 64'(bus.pending_o), 64'd0);
    wait_done(base + 16'd1, 500, "fl_retire");
    repeat (10) tick();
    chk("fl_only_one", 64'({bus.done_cnt_o, 8'(seen_ops.size()), bus.pending_o}), 64'({base + 16'd1, 8'd1, 3'd0}));
    // stale op_end holds issue; then async reset during WAIT_END
    auto_en = 0;
    oe_man  = 1;
    seen_ops.delete();
    push_cmd(2'b10, "st_push");
    push_cmd(2'b01, "st_push");
    repeat (5) tick();
    chk("st_hold", 64'({bus.pending_o, bus.busy_o, 8'(seen_ops.size())}), 64'({3'd2, 1'b0, 8'd0}));
    oe_man = 0;
    begin
      int g = 0;
      while (!bus.busy_o && g < 20) begin tick(); g++; end
    end
    tick();
    tick();
    chk("st_issue", 64'({pk(), bus.pending_o, bus.busy_o}), 64'({60'h1, 3'd1, 1'b1}));
    #1 rst_ni = 0;
    #1 chk("async_rst", 64'(outs()), 64'({1'b1, 4'h0, 1'b0, 3'd0, 16'd0, 1'b0}));
    tick();
    rst_ni = 1;
    tick();
    // random traffic, every cycle compared against the reference
    auto_en = 1;
    rnd = 1;
    for (int k = 0; k < 3000; k++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1) * 3) : 2'($urandom_range(1, 2)),
            1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 19) == 0));
      tick();
    end
    drive(0, 0, 0, 0);
    repeat (100) tick();
    chk("rnd_drain", 64'({bus.pending_o, bus.busy_o}), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
